// File: rtl/console_pkg.sv
// Shared constants and types for the text console writer.
// Holds grid defaults, character codes, printable bounds and the FSM state enum.
// Optional feature macro: CONSOLE_CLEAR_EN adds the full-screen clear state.
package console_pkg;

    localparam int unsigned COLS_DEF   = 80;
    localparam int unsigned ROWS_DEF   = 30;
    localparam int unsigned ADDR_W_DEF = 13;

    // Cursor port widths are fixed by the interface
    localparam int unsigned COL_W = 7;
    localparam int unsigned ROW_W = 5;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLRLINE = 2'd1
`ifdef CONSOLE_CLEAR_EN
        ,
        CLRSCR  = 2'd2
`endif
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHR_PRINT_LO) && (b <= CHR_PRINT_HI);
    endfunction

endpackage

// File: rtl/cell_addr.sv
// Combinational row/col to linear text RAM address: row*COLS + col.
// Ports: i_row (cursor row), i_col (cursor column), o_addr_c (ADDR_W-bit address).
module cell_addr
    import console_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    output logic [ADDR_W-1:0] o_addr_c
);

    generate
        if (COLS == 80) begin : g_shift
            // 80*row as 64*row + 16*row, no multiplier needed
            always_comb begin
                o_addr_c = (ADDR_W'(i_row) << 6) + (ADDR_W'(i_row) << 4) + ADDR_W'(i_col);
            end
        end else begin : g_mul
            always_comb begin
                o_addr_c = ADDR_W'(i_row) * ADDR_W'(COLS) + ADDR_W'(i_col);
            end
        end
    endgenerate

endmodule

// File: rtl/text_console_writer.sv
// Character-stream front end for the text display: accepts ASCII bytes on a
// valid/ready handshake, tracks the cursor and writes cells of the text RAM.
// Ports:
//   i_clk, i_reset            single clock, synchronous active-high reset
//   i_dat, i_valid, o_ready   byte input handshake
//   o_ram_addr/dat/we         text RAM write port, one cell per cycle
//   o_cursor_col/row          current cursor position
// Optional feature macro: CONSOLE_CLEAR_EN (form feed clears the whole screen).
module text_console_writer
    import console_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_dat,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_dat,
    output logic              o_ram_we,
    output logic [COL_W-1:0]  o_cursor_col,
    output logic [ROW_W-1:0]  o_cursor_row
);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   clr_col_q, clr_col_d;
`ifdef CONSOLE_CLEAR_EN
    logic [ROW_W-1:0]   clr_row_q, clr_row_d;
`endif
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [7:0]         ram_dat_q, ram_dat_d;

    logic [ROW_W-1:0]   adv_row;
    logic [ROW_W-1:0]   sel_row;
    logic [COL_W-1:0]   sel_col;
    logic [ADDR_W-1:0]  cell_addr_c;
    logic               accept;

    // Ready is gated by reset directly so no byte is taken while reset is high
    assign o_ready = (state_q == IDLE) && !i_reset;
    assign accept  = i_valid && o_ready;

    // Next row with wrap from the bottom row to the top
    always_comb begin
        adv_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 5'd1;
    end

    // Single address generator; pick the cell each state/byte targets
    always_comb begin
        sel_row = row_q;
        sel_col = col_q;
        case (state_q)
            IDLE: begin
                if (i_dat == CHR_LF) begin
                    sel_row = adv_row;
                    sel_col = '0;
                end else if (i_dat == CHR_BS) begin
                    sel_col = col_q - 7'd1;
                end
            end
            CLRLINE: begin
                sel_col = clr_col_q;
            end
`ifdef CONSOLE_CLEAR_EN
            CLRSCR: begin
                sel_row = clr_row_q;
                sel_col = clr_col_q;
            end
`endif
            default: ;
        endcase
    end

    cell_addr #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_cell_addr (
        .i_row    (sel_row),
        .i_col    (sel_col),
        .o_addr_c (cell_addr_c)
    );

    // Next-state, cursor and RAM write port
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        clr_col_d  = clr_col_q;
`ifdef CONSOLE_CLEAR_EN
        clr_row_d  = clr_row_q;
`endif
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_dat_d  = ram_dat_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(i_dat)) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = cell_addr_c;
                        ram_dat_d  = i_dat;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d     = '0;
                            row_d     = adv_row;
                            clr_col_d = '0;
                            state_d   = CLRLINE;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else if (i_dat == CHR_LF) begin
                        // First cell of the new row is cleared right away
                        ram_we_d   = 1'b1;
                        ram_addr_d = cell_addr_c;
                        ram_dat_d  = CHR_SPACE;
                        col_d      = '0;
                        row_d      = adv_row;
                        clr_col_d  = 7'd1;
                        state_d    = CLRLINE;
                    end else if (i_dat == CHR_CR) begin
                        col_d = '0;
                    end else if (i_dat == CHR_BS) begin
                        if (col_q != '0) begin
                            ram_we_d   = 1'b1;
                            ram_addr_d = cell_addr_c;
                            ram_dat_d  = CHR_SPACE;
                            col_d      = col_q - 7'd1;
                        end
                    end
`ifdef CONSOLE_CLEAR_EN
                    else if (i_dat == CHR_FF) begin
                        col_d     = '0;
                        row_d     = '0;
                        clr_col_d = '0;
                        clr_row_d = '0;
                        state_d   = CLRSCR;
                    end
`endif
                end
            end

            CLRLINE: begin
                // Counter runs one past the last column so ready rises a cycle after the final write
                if (clr_col_q == COL_W'(COLS)) begin
                    state_d = IDLE;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cell_addr_c;
                    ram_dat_d  = CHR_SPACE;
                    clr_col_d  = clr_col_q + 7'd1;
                end
            end

`ifdef CONSOLE_CLEAR_EN
            CLRSCR: begin
                if (clr_row_q == ROW_W'(ROWS)) begin
                    state_d = IDLE;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cell_addr_c;
                    ram_dat_d  = CHR_SPACE;
                    if (clr_col_q == COL_W'(COLS - 1)) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row_q + 5'd1;
                    end else begin
                        clr_col_d = clr_col_q + 7'd1;
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            clr_col_q  <= '0;
`ifdef CONSOLE_CLEAR_EN
            clr_row_q  <= '0;
`endif
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            clr_col_q  <= clr_col_d;
`ifdef CONSOLE_CLEAR_EN
            clr_row_q  <= clr_row_d;
`endif
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_dat_q  <= ram_dat_d;
        end
    end

    assign o_ram_we     = ram_we_q;
    assign o_ram_addr   = ram_addr_q;
    assign o_ram_dat    = ram_dat_q;
    assign o_cursor_col = col_q;
    assign o_cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: randomized byte streams checked
// against a screen-level reference model of cursor movement and cell writes.
module tb_text_console_writer;

    localparam int TB_COLS = 80;
    localparam int TB_ROWS = 30;

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  i_dat;
    logic        i_valid;
    logic        o_ready;
    logic [12:0] o_ram_addr;
    logic [7:0]  o_ram_dat;
    logic        o_ram_we;
    logic [6:0]  o_cursor_col;
    logic [4:0]  o_cursor_row;

    text_console_writer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dat        (i_dat),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_ram_addr   (o_ram_addr),
        .o_ram_dat    (o_ram_dat),
        .o_ram_we     (o_ram_we),
        .o_cursor_col (o_cursor_col),
        .o_cursor_row (o_cursor_row)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int     addr;
        int     dat;
        longint cyc;
    } wr_t;

    wr_t    got_q[$];
    wr_t    exp_q[$];
    longint cyc = 0;
    int     low_cnt = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     mc = 0;
    int     mr = 0;

    always @(posedge i_clk) cyc++;

    // Record every RAM write and count cycles with ready low outside reset
    always @(negedge i_clk) begin
        if (o_ram_we === 1'b1) got_q.push_back('{int'(o_ram_addr), int'(o_ram_dat), cyc});
        if (o_ready !== 1'b1 && i_reset === 1'b0) low_cnt++;
    end

    // Reference model: what the screen should receive for one byte
    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back('{mr * TB_COLS + mc, int'(b), 0});
            if (mc == TB_COLS - 1) begin
                mc = 0;
                mr = (mr + 1) % TB_ROWS;
                for (int k = 0; k < TB_COLS; k++) exp_q.push_back('{mr * TB_COLS + k, 32, 0});
            end else begin
                mc++;
            end
        end else if (b == 8'h0A) begin
            mc = 0;
            mr = (mr + 1) % TB_ROWS;
            for (int k = 0; k < TB_COLS; k++) exp_q.push_back('{mr * TB_COLS + k, 32, 0});
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                exp_q.push_back('{mr * TB_COLS + mc, 32, 0});
            end
        end
`ifdef CONSOLE_CLEAR_EN
        else if (b == 8'h0C) begin
            for (int k = 0; k < TB_COLS * TB_ROWS; k++) exp_q.push_back('{k, 32, 0});
            mc = 0;
            mr = 0;
        end
`endif
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[i])
            if (got_q[i].addr != exp_q[i].addr || got_q[i].dat != exp_q[i].dat) return i;
        return -1;
    endfunction

    function automatic longint cyc_span(input int first, input int last);
        if (got_q.size() <= last) return -1;
        return got_q[last].cyc - got_q[first].cyc;
    endfunction

    task automatic flush();
        got_q.delete();
        exp_q.delete();
    endtask

    // Present a byte and hold it until accepted (bounded)
    task automatic send(input logic [7:0] b);
        int guard = 0;
        @(negedge i_clk);
        i_dat   = b;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && guard < 5000) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: ready stayed %b, required 1", o_ready);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        model_byte(b);
        send(b);
    endtask

    // Wait for ready (bounded), then one more cycle so writes are recorded
    task automatic settle();
        int guard = 0;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && guard < 5000) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL settle_timeout: ready stayed %b, required 1", o_ready);
        end
        @(negedge i_clk);
        #1;
    endtask

    function automatic logic [7:0] rand_print();
        return 8'(32'h20 + $urandom_range(0, 94));
    endfunction

    task automatic apply_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        mc = 0;
        mr = 0;
        @(negedge i_clk);
        #1;
        flush();
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b need 0", o_ready); end
        n_cmp++; if (o_ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b need 0", o_ram_we); end
        n_cmp++; if (o_ram_addr !== 13'd0) begin n_fail++; $display("FAIL reset_addr: got %0d need 0", o_ram_addr); end
        n_cmp++; if (o_ram_dat !== 8'd0) begin n_fail++; $display("FAIL reset_dat: got %0h need 0", o_ram_dat); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd0) begin
            n_fail++; $display("FAIL reset_cursor: got (%0d,%0d) need (0,0)", o_cursor_col, o_cursor_row);
        end
        i_reset = 1'b0;
        @(negedge i_clk);
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b need 1", o_ready); end
        mc = 0;
        mr = 0;
        flush();
    endtask

    task automatic test_back_to_back();
        int d;
        low_cnt = 0;
        put(8'h41);
        put(8'h42);
        settle();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL b2b_writes: diff %0d got_n %0d need_n %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (cyc_span(0, 1) != 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d need 1", cyc_span(0, 1)); end
        n_cmp++; if (low_cnt != 0) begin n_fail++; $display("FAIL b2b_ready: low %0d cycles need 0", low_cnt); end
        n_cmp++; if (o_cursor_col !== 7'd2 || o_cursor_row !== 5'd0) begin
            n_fail++; $display("FAIL b2b_cursor: got (%0d,%0d) need (2,0)", o_cursor_col, o_cursor_row);
        end
        flush();
    endtask

    task automatic test_col_wrap();
        int d;
        while (mc != TB_COLS - 1) put(rand_print());
        settle();
        flush();
        low_cnt = 0;
        put(8'h5A);
        settle();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL wrap_writes: diff %0d got_n %0d need_n %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (got_q.size() < 1 || got_q[0].addr != 79 || got_q[0].dat != 8'h5A) begin
            n_fail++; $display("FAIL wrap_char: first write wrong, need addr 79 = 5a");
        end
        n_cmp++; if (cyc_span(0, 80) != 80) begin n_fail++; $display("FAIL wrap_span: got %0d need 80", cyc_span(0, 80)); end
        n_cmp++; if (low_cnt != 81) begin n_fail++; $display("FAIL wrap_ready_low: got %0d need 81", low_cnt); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd1) begin
            n_fail++; $display("FAIL wrap_cursor: got (%0d,%0d) need (0,1)", o_cursor_col, o_cursor_row);
        end
        flush();
    endtask

    task automatic test_lf_row_wrap();
        int d;
        while (mr != TB_ROWS - 1) put(8'h0A);
        repeat (5) put(rand_print());
        settle();
        flush();
        low_cnt = 0;
        put(8'h0A);
        settle();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL lf_writes: diff %0d got_n %0d need_n %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (got_q.size() < 1 || got_q[0].addr != 0) begin n_fail++; $display("FAIL lf_first_addr: need addr 0 first"); end
        n_cmp++; if (low_cnt != 80) begin n_fail++; $display("FAIL lf_ready_low: got %0d need 80", low_cnt); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd0) begin
            n_fail++; $display("FAIL lf_cursor: got (%0d,%0d) need (0,0)", o_cursor_col, o_cursor_row);
        end
        flush();
    endtask

    task automatic test_bs_cr();
        put(8'h0A);
        put(8'h0A);
        repeat (3) put(rand_print());
        settle();
        flush();
        put(8'h08);
        settle();
        n_cmp++; if (got_q.size() != 1 || got_q[0].addr != 162 || got_q[0].dat != 32) begin
            n_fail++; $display("FAIL bs_write: got %0d writes, need one at 162 = 20", got_q.size());
        end
        n_cmp++; if (o_cursor_col !== 7'd2 || o_cursor_row !== 5'd2) begin
            n_fail++; $display("FAIL bs_cursor: got (%0d,%0d) need (2,2)", o_cursor_col, o_cursor_row);
        end
        put(8'h08);
        put(8'h08);
        settle();
        flush();
        put(8'h08);
        settle();
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bs_col0_write: got %0d writes need 0", got_q.size()); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd2) begin
            n_fail++; $display("FAIL bs_col0_cursor: got (%0d,%0d) need (0,2)", o_cursor_col, o_cursor_row);
        end
        repeat (40) put(rand_print());
        settle();
        flush();
        put(8'h0D);
        settle();
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL cr_write: got %0d writes need 0", got_q.size()); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd2) begin
            n_fail++; $display("FAIL cr_cursor: got (%0d,%0d) need (0,2)", o_cursor_col, o_cursor_row);
        end
        flush();
    endtask

    task automatic test_ignored();
        put(rand_print());
        put(rand_print());
        settle();
        flush();
        low_cnt = 0;
        put(8'h07);
        put(8'h80);
`ifndef CONSOLE_CLEAR_EN
        put(8'h0C);
`endif
        settle();
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ignored_write: got %0d writes need 0", got_q.size()); end
        n_cmp++; if (low_cnt != 0) begin n_fail++; $display("FAIL ignored_ready: low %0d cycles need 0", low_cnt); end
        n_cmp++; if (o_cursor_col !== 7'(mc) || o_cursor_row !== 5'(mr)) begin
            n_fail++; $display("FAIL ignored_cursor: got (%0d,%0d) need (%0d,%0d)", o_cursor_col, o_cursor_row, mc, mr);
        end
        flush();
    endtask

    task automatic test_random();
        int d;
        int r;
        logic [7:0] b;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = rand_print();
            else if (r < 67) b = 8'h0A;
            else if (r < 75) b = 8'h0D;
            else if (r < 88) b = 8'h08;
            else             b = 8'($urandom_range(0, 255));
            put(b);
        end
        settle();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL random_writes: diff %0d got_n %0d need_n %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (o_cursor_col !== 7'(mc) || o_cursor_row !== 5'(mr)) begin
            n_fail++; $display("FAIL random_cursor: got (%0d,%0d) need (%0d,%0d)", o_cursor_col, o_cursor_row, mc, mr);
        end
        flush();
    endtask

`ifdef CONSOLE_CLEAR_EN
    task automatic test_clrscr();
        int d;
        int guard;
        apply_reset();
        repeat (10) put(8'h0A);
        repeat (10) put(rand_print());
        settle();
        flush();
        low_cnt = 0;
        put(8'h0C);
        settle();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL clrscr_writes: diff %0d got_n %0d need_n %0d", d, got_q.size(), exp_q.size()); end
        n_cmp++; if (low_cnt != 2401) begin n_fail++; $display("FAIL clrscr_ready_low: got %0d need 2401", low_cnt); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd0) begin
            n_fail++; $display("FAIL clrscr_cursor: got (%0d,%0d) need (0,0)", o_cursor_col, o_cursor_row);
        end
        flush();
        // Reset in the middle of a full clear
        put(rand_print());
        put(8'h0C);
        guard = 0;
        while (!(o_ram_we === 1'b1 && o_ram_addr === 13'd500) && guard < 3000) begin
            @(negedge i_clk);
            guard++;
        end
        n_cmp++; if (guard >= 3000) begin n_fail++; $display("FAIL clrscr_reach_500: write to 500 not seen"); end
        i_reset = 1'b1;
        @(negedge i_clk);
        n_cmp++; if (o_ram_we !== 1'b0) begin n_fail++; $display("FAIL clrscr_reset_we: got %b need 0", o_ram_we); end
        i_reset = 1'b0;
        @(negedge i_clk);
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL clrscr_reset_ready: got %b need 1", o_ready); end
        n_cmp++; if (o_cursor_col !== 7'd0 || o_cursor_row !== 5'd0) begin
            n_fail++; $display("FAIL clrscr_reset_cursor: got (%0d,%0d) need (0,0)", o_cursor_col, o_cursor_row);
        end
        mc = 0;
        mr = 0;
        flush();
    endtask
`endif

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_dat   = 8'h00;
        test_reset();
        test_back_to_back();
        test_col_wrap();
        test_lf_row_wrap();
        test_bs_cr();
        test_ignored();
        test_random();
`ifdef CONSOLE_CLEAR_EN
        test_clrscr();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
